// File: rtl/crossbar_input_arbiter_if.sv
// AXI4-Stream bundle for the crossbar input arbiter: NUM_INPUTS ingress streams plus one merged egress stream.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface crossbar_input_arbiter_if #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_INPUTS           = 5
);
    logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata;
    logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb;
    logic [NUM_INPUTS*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser;
    logic [NUM_INPUTS-1:0]                         s_axis_tvalid;
    logic [NUM_INPUTS-1:0]                         s_axis_tlast;
    logic [NUM_INPUTS-1:0]                         s_axis_tready;

    logic [C_M_AXIS_DATA_WIDTH-1:0]                m_axis_tdata;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser;
    logic                                          m_axis_tvalid;
    logic                                          m_axis_tlast;
    logic                                          m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/crossbar_input_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS AXI4-Stream inputs into one output stream,
// with per-input enable mask and a forwarded-packet counter.
//
// state | meaning
// IDLE  | no lock; pick next requester after grant_sel, all tready low, no output valid
// PKT   | locked to grant_sel; combinational pass-through until the tlast beat transfers
module crossbar_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_INPUTS           = 5,
    parameter int SEL_WIDTH            = 3
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    crossbar_input_arbiter_if.slave axis,
    input  logic [NUM_INPUTS-1:0]   in_enable,
    output logic [SEL_WIDTH-1:0]    grant_sel,
    output logic [31:0]             pkt_count
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL_WIDTH-1:0]   r_grant_sel;
    logic [SEL_WIDTH-1:0]   w_grant_nxt;
    logic [31:0]            r_pkt_count;
    logic                   w_cnt_inc;

    logic [NUM_INPUTS-1:0]  w_req;
    logic                   w_found;
    logic [SEL_WIDTH-1:0]   w_pick;

    logic [DW-1:0]          w_sel_tdata;
    logic [SW-1:0]          w_sel_tstrb;
    logic [UW-1:0]          w_sel_tuser;
    logic                   w_sel_tvalid;
    logic                   w_sel_tlast;
    logic                   w_xfer;
    logic [NUM_INPUTS-1:0]  w_tready;

    assign w_req = axis.s_axis_tvalid & in_enable;

    // Rotating priority: first look strictly above the last grant, then wrap from 0 up to it.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_grant_sel;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!w_found && w_req[i] && (i > int'(r_grant_sel))) begin
                w_found = 1'b1;
                w_pick  = SEL_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!w_found && w_req[i]) begin
                w_found = 1'b1;
                w_pick  = SEL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_sel_tdata  = '0;
        w_sel_tstrb  = '0;
        w_sel_tuser  = '0;
        w_sel_tvalid = 1'b0;
        w_sel_tlast  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_grant_sel == SEL_WIDTH'(i)) begin
                w_sel_tdata  = axis.s_axis_tdata[i*DW +: DW];
                w_sel_tstrb  = axis.s_axis_tstrb[i*SW +: SW];
                w_sel_tuser  = axis.s_axis_tuser[i*UW +: UW];
                w_sel_tvalid = axis.s_axis_tvalid[i];
                w_sel_tlast  = axis.s_axis_tlast[i];
            end
        end
    end

    always_comb begin
        w_tready = '0;
        if (r_state == ST_PKT) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (r_grant_sel == SEL_WIDTH'(i)) begin
                    w_tready[i] = axis.m_axis_tready;
                end
            end
        end
    end

    assign w_xfer = (r_state == ST_PKT) && w_sel_tvalid && axis.m_axis_tready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_sel;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_PKT;
                    w_grant_nxt = w_pick;
                end
            end
            ST_PKT: begin
                if (w_xfer && w_sel_tlast) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_inc   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state     <= ST_IDLE;
            r_grant_sel <= SEL_WIDTH'(NUM_INPUTS - 1);
            r_pkt_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_sel <= w_grant_nxt;
            if (w_cnt_inc) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    // Payload is always driven from the current grant; only valid is gated by the lock.
    assign axis.m_axis_tdata  = w_sel_tdata;
    assign axis.m_axis_tstrb  = w_sel_tstrb;
    assign axis.m_axis_tuser  = w_sel_tuser;
    assign axis.m_axis_tlast  = w_sel_tlast;
    assign axis.m_axis_tvalid = (r_state == ST_PKT) && w_sel_tvalid;
    assign axis.s_axis_tready = w_tready;

    assign grant_sel = r_grant_sel;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_crossbar_input_arbiter.sv
// Directed bench for crossbar_input_arbiter: queue-driven sources, a per-cycle reference model
// of the round-robin packet arbiter, and literal expectations per scenario.
module tb_crossbar_input_arbiter;

    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int SB  = DW / 8;
    localparam int N   = 5;
    localparam int SLW = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    en;
    logic [SLW-1:0]  grant_sel;
    logic [31:0]     pkt_count;

    always #5 clk = ~clk;

    crossbar_input_arbiter_if #(
        .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
        .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
        .NUM_INPUTS(N)
    ) bus ();

    crossbar_input_arbiter #(
        .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
        .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
        .NUM_INPUTS(N), .SEL_WIDTH(SLW)
    ) dut (
        .axi_aclk   (clk),
        .axi_resetn (rst_n),
        .axis       (bus),
        .in_enable  (en),
        .grant_sel  (grant_sel),
        .pkt_count  (pkt_count)
    );

    typedef struct {
        logic [31:0] tag;
        logic        last;
    } beat_t;

    beat_t        srcq [N][$];
    logic [N-1:0] hold;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: lock flag, current grant, packet count
    bit          m_busy;
    int          m_grant;
    logic [31:0] m_count;

    int          grant_log[$];
    logic [31:0] out_tag[$];
    int          out_cyc[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        logic [31:0] t;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && !hold[i]) begin
                t = srcq[i][0].tag;
                bus.s_axis_tvalid[i]          = 1'b1;
                bus.s_axis_tlast[i]           = srcq[i][0].last;
                bus.s_axis_tdata[i*DW +: DW]  = {8{t}};
                bus.s_axis_tstrb[i*SB +: SB]  = t;
                bus.s_axis_tuser[i*UW +: UW]  = {4{t}};
            end else begin
                bus.s_axis_tvalid[i]          = 1'b0;
                bus.s_axis_tlast[i]           = 1'b0;
                bus.s_axis_tdata[i*DW +: DW]  = '0;
                bus.s_axis_tstrb[i*SB +: SB]  = '0;
                bus.s_axis_tuser[i*UW +: UW]  = '0;
            end
        end
    endtask

    task automatic add_pkt(input int i, input int nbeats, input int base);
        beat_t bt;
        for (int b = 0; b < nbeats; b++) begin
            bt.tag  = 32'(base + b);
            bt.last = (b == nbeats - 1);
            srcq[i].push_back(bt);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        out_tag.delete();
        out_cyc.delete();
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_grant = N - 1;
        m_count = '0;
    endtask

    // One clock: compare at negedge, advance model and sources at posedge, redrive at posedge+1.
    task automatic step();
        logic [N-1:0] req;
        logic [N-1:0] fire;
        logic [N-1:0] exp_rdy;
        logic [31:0]  t;
        bit           nb;
        int           ng;
        logic [31:0]  nc;
        int           g;
        @(negedge clk);
        g = m_grant;
        chk("grant_sel", grant_sel, m_grant);
        chk("pkt_count", pkt_count, m_count);
        if (m_busy) begin
            exp_rdy    = '0;
            exp_rdy[g] = bus.m_axis_tready;
            chk("m_tvalid", bus.m_axis_tvalid, bus.s_axis_tvalid[g]);
            chk("s_tready", bus.s_axis_tready, exp_rdy);
            if (bus.s_axis_tvalid[g]) begin
                t = srcq[g][0].tag;
                chk("m_tdata", bus.m_axis_tdata, {8{t}});
                chk("m_tstrb", bus.m_axis_tstrb, t);
                chk("m_tuser", bus.m_axis_tuser, {4{t}});
                chk("m_tlast", bus.m_axis_tlast, srcq[g][0].last);
            end
        end else begin
            chk("m_tvalid_idle", bus.m_axis_tvalid, 1'b0);
            chk("s_tready_idle", bus.s_axis_tready, '0);
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            out_tag.push_back(bus.m_axis_tdata[31:0]);
            out_cyc.push_back(cyc);
        end
        fire = bus.s_axis_tvalid & bus.s_axis_tready;
        nb = m_busy;
        ng = m_grant;
        nc = m_count;
        if (!m_busy) begin
            req = bus.s_axis_tvalid & en;
            if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (!nb && req[(m_grant + k) % N]) begin
                        nb = 1'b1;
                        ng = (m_grant + k) % N;
                    end
                end
                grant_log.push_back(ng);
            end
        end else if (bus.s_axis_tvalid[g] && bus.m_axis_tready && bus.s_axis_tlast[g]) begin
            nb = 1'b0;
            nc = m_count + 32'd1;
        end
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            m_busy  = nb;
            m_grant = ng;
            m_count = nc;
            for (int i = 0; i < N; i++) begin
                if (fire[i]) srcq[i].pop_front();
            end
        end
        #1;
        drive_inputs();
    endtask

    // Asserted between clock edges so the outputs must drop with no edge at all.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_m_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("rst_s_tready", bus.s_axis_tready, '0);
        chk("rst_grant_sel", grant_sel, 4);
        chk("rst_pkt_count", pkt_count, 0);
        model_reset();
        for (int i = 0; i < N; i++) srcq[i].delete();
        hold = '0;
        drive_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int exp2[6] = '{0, 1, 4, 0, 1, 4};
    int exp4[7] = '{2, 3, 4, 1, 2, 3, 4};
    logic [31:0] exp3[6] = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h100, 32'h101};
    logic [31:0] cnt_before;

    initial begin
        en                 = '1;
        hold               = '0;
        bus.m_axis_tready  = 1'b1;
        bus.s_axis_tvalid  = '0;
        bus.s_axis_tlast   = '0;
        bus.s_axis_tdata   = '0;
        bus.s_axis_tstrb   = '0;
        bus.s_axis_tuser   = '0;
        model_reset();
        drive_inputs();
        @(posedge clk);
        #1;
        chk("reset_grant_sel", grant_sel, 4);
        chk("reset_pkt_count", pkt_count, 0);
        chk("reset_m_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("reset_s_tready", bus.s_axis_tready, '0);
        rst_n = 1'b1;

        // Single 3-beat packet on input 2
        clear_logs();
        add_pkt(2, 3, 'h200);
        drive_inputs();
        step();
        chk("t1_grant_after_1", grant_sel, 2);
        repeat (5) step();
        chk("t1_ngrants", grant_log.size(), 1);
        chk("t1_nbeats", out_tag.size(), 3);
        if (out_tag.size() == 3) begin
            chk("t1_beat0", out_tag[0], 'h200);
            chk("t1_beat2", out_tag[2], 'h202);
            chk("t1_consecutive", out_cyc[2] - out_cyc[0], 2);
        end
        chk("t1_pkt_count", pkt_count, 1);

        // Inputs 0,1,4 with back-to-back 2-beat packets
        async_reset();
        clear_logs();
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 2, 'h1000 + r*16);
            add_pkt(1, 2, 'h1100 + r*16);
            add_pkt(4, 2, 'h1400 + r*16);
        end
        drive_inputs();
        repeat (18) step();
        chk("t2_pkt_count", pkt_count, 6);
        chk("t2_ngrants", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("t2_grant_order", grant_log[k], exp2[k]);
        if (out_cyc.size() == 12) chk("t2_idle_gap", out_cyc[10] - out_cyc[0], 15);
        else chk("t2_nbeats", out_cyc.size(), 12);

        // Backpressure and a source bubble on input 3 while input 1 waits
        clear_logs();
        add_pkt(3, 4, 'h300);
        drive_inputs();
        step();
        step();
        add_pkt(1, 2, 'h100);
        drive_inputs();
        bus.m_axis_tready = 1'b0;
        step();
        step();
        bus.m_axis_tready = 1'b1;
        step();
        hold[3] = 1'b1;
        drive_inputs();
        step();
        hold[3] = 1'b0;
        drive_inputs();
        repeat (8) step();
        chk("t3_nbeats", out_tag.size(), 6);
        for (int k = 0; k < 6 && k < out_tag.size(); k++) chk("t3_beat_order", out_tag[k], exp3[k]);
        chk("t3_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) chk("t3_second_grant", grant_log[1], 1);

        // Enable mask: input 0 never eligible, input 1 disabled while its packet is running
        clear_logs();
        cnt_before = pkt_count;
        en = 5'b11110;
        for (int i = 0; i < N; i++) begin
            add_pkt(i, 2, 'h4000 + i*256);
            add_pkt(i, 2, 'h4010 + i*256);
        end
        drive_inputs();
        for (int s = 0; s < 24; s++) begin
            step();
            if (m_busy && m_grant == 1 && en[1]) en[1] = 1'b0;
        end
        chk("t4_ngrants", grant_log.size(), 7);
        for (int k = 0; k < 7 && k < grant_log.size(); k++) chk("t4_grant_order", grant_log[k], exp4[k]);
        chk("t4_pkt_delta", pkt_count - cnt_before, 7);
        chk("t4_in0_untouched", srcq[0].size(), 4);
        chk("t4_in1_left", srcq[1].size(), 2);
        srcq[0].delete();
        srcq[1].delete();
        en = '1;
        drive_inputs();
        step();

        // Single-beat packets alternating between inputs 0 and 1
        clear_logs();
        cnt_before = pkt_count;
        for (int r = 0; r < 3; r++) begin
            add_pkt(0, 1, 'h500 + r);
            add_pkt(1, 1, 'h510 + r);
        end
        drive_inputs();
        repeat (12) step();
        chk("t5_pkt_delta", pkt_count - cnt_before, 6);
        chk("t5_ngrants", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("t5_alternate", grant_log[k], k % 2);
        for (int k = 1; k < out_cyc.size(); k++) chk("t5_two_cycle_spacing", out_cyc[k] - out_cyc[k-1], 2);

        // Asynchronous reset in the middle of an input 2 packet
        clear_logs();
        add_pkt(2, 4, 'h600);
        drive_inputs();
        step();
        step();
        chk("t6_mid_pkt_valid", bus.m_axis_tvalid, 1'b1);
        async_reset();
        clear_logs();
        add_pkt(0, 1, 'h700);
        add_pkt(2, 1, 'h720);
        drive_inputs();
        repeat (6) step();
        chk("t6_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t6_first_after_reset", grant_log[0], 0);
            chk("t6_second_after_reset", grant_log[1], 2);
        end
        chk("t6_pkt_count", pkt_count, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
